// File: rtl/seven_seg_pkg.sv
// Shared types, constants and the hex-to-segment table for the
// four-digit active-low seven-segment scanner.
package seven_seg_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t       SEG_BLANK = 7'b1111111;
    localparam logic [0:3] ANODE_OFF = 4'b1111;

    // Each digit slot opens with an all-off interval, then drives its digit.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational nibble to active-low a..g pattern, with a blank override
// used for leading-zero suppression.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [0:6] o_segment
);

    always_comb begin
        o_segment = hex_to_seg(i_nibble);
        if (i_blank) begin
            o_segment = SEG_BLANK;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes a 16-bit hex snapshot onto four common-anode digits;
// new values are applied only at frame boundaries so the display never tears.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter int BLANK_CYCLES  = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic [0:15] i_value,
    input  logic        i_load,
    input  logic [0:3]  i_dot,
    output logic [0:6]  o_segment_enable,
    output logic [0:3]  o_display_enable,
    output logic        o_dot_enable,
    output logic        o_frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [0:15]      displayed_q, displayed_d;
    logic [0:15]      pending_q, pending_d;
    logic             pending_valid_q, pending_valid_d;
    logic [0:6]       seg_q, seg_d;
    logic [0:3]       anode_q, anode_d;
    logic             dot_q, dot_d;
    logic             tick_q, tick_d;

    logic       slot_last;
    logic       frame_end;
    phase_t     phase;
    logic [3:0] cur_nibble;
    logic [3:0] nib_zero;
    logic [3:0] lead_zero;
    logic       blank_digit;
    logic [0:6] dec_seg;

    always_comb begin
        slot_last = (cnt_q == CNT_LAST);
        frame_end = slot_last && (idx_q == 2'd3);
        cnt_d     = slot_last ? '0 : cnt_q + CNT_W'(1);
        idx_d     = slot_last ? idx_q + 2'd1 : idx_q;
    end

    // A load on the boundary cycle is the newest value, so it bypasses pending.
    always_comb begin
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        displayed_d     = displayed_q;
        if (frame_end) begin
            if (i_load) begin
                displayed_d = i_value;
            end else if (pending_valid_q) begin
                displayed_d = pending_q;
            end
            pending_valid_d = 1'b0;
        end else if (i_load) begin
            pending_d       = i_value;
            pending_valid_d = 1'b1;
        end
    end

    always_comb begin
        cur_nibble = displayed_q[{idx_q, 2'b00} +: 4];
        for (int k = 0; k < 4; k++) begin
            nib_zero[k] = (displayed_q[k*4 +: 4] == 4'h0);
        end
        // Digit 3 always shows, so a value of zero reads as a single 0.
        lead_zero[0] = nib_zero[0];
        lead_zero[1] = nib_zero[0] & nib_zero[1];
        lead_zero[2] = nib_zero[0] & nib_zero[1] & nib_zero[2];
        lead_zero[3] = 1'b0;
        blank_digit  = (BLANK_LEADING != 0) && lead_zero[idx_q];
    end

    seven_seg_decoder u_decoder (
        .i_nibble  (cur_nibble),
        .i_blank   (blank_digit),
        .o_segment (dec_seg)
    );

    always_comb begin
        phase   = (cnt_q < BLANK_END) ? PH_BLANK : PH_DRIVE;
        seg_d   = SEG_BLANK;
        anode_d = ANODE_OFF;
        dot_d   = 1'b1;
        tick_d  = frame_end;
        if (phase == PH_DRIVE) begin
            anode_d[idx_q] = 1'b0;
            seg_d          = dec_seg;
            dot_d          = ~i_dot[idx_q];
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q           <= '0;
            idx_q           <= 2'd0;
            displayed_q     <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            seg_q           <= SEG_BLANK;
            anode_q         <= ANODE_OFF;
            dot_q           <= 1'b1;
            tick_q          <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            displayed_q     <= displayed_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            seg_q           <= seg_d;
            anode_q         <= anode_d;
            dot_q           <= dot_d;
            tick_q          <= tick_d;
        end
    end

    assign o_segment_enable = seg_q;
    assign o_display_enable = anode_q;
    assign o_dot_enable     = dot_q;
    assign o_frame_tick     = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: two instances (leading-zero blanking
// on and off) share stimulus and are checked cycle by cycle over whole frames.
module tb_seven_seg_scanner;

    localparam int RD = 8;
    localparam int BC = 2;

    localparam logic [0:6] SX = 7'b1111111;
    localparam logic [0:6] S0 = 7'b0000001;
    localparam logic [0:6] S1 = 7'b1001111;
    localparam logic [0:6] S2 = 7'b0010010;
    localparam logic [0:6] S3 = 7'b0000110;
    localparam logic [0:6] S5 = 7'b0100100;
    localparam logic [0:6] S8 = 7'b0000000;
    localparam logic [0:6] SA = 7'b0001000;
    localparam logic [0:6] SLB = 7'b1100000;
    localparam logic [0:6] SE = 7'b0110000;
    localparam logic [0:6] SF = 7'b0111000;

    typedef struct packed {
        logic [15:0]      value;
        logic [0:3]       dot;
        logic [0:3][0:6]  exp_a;
        logic [0:3][0:6]  exp_b;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [0:15] i_value;
    logic        i_load;
    logic [0:3]  i_dot;
    logic [0:6]  seg_a, seg_b;
    logic [0:3]  disp_a, disp_b;
    logic        dot_a, dot_b;
    logic        tick_a, tick_b;

    int tests_run;
    int tests_failed;

    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLANK_LEADING(1)) dut_a (
        .clk              (clk),
        .i_reset          (rst),
        .i_value          (i_value),
        .i_load           (i_load),
        .i_dot            (i_dot),
        .o_segment_enable (seg_a),
        .o_display_enable (disp_a),
        .o_dot_enable     (dot_a),
        .o_frame_tick     (tick_a)
    );

    seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .BLANK_LEADING(0)) dut_b (
        .clk              (clk),
        .i_reset          (rst),
        .i_value          (i_value),
        .i_load           (i_load),
        .i_dot            (i_dot),
        .o_segment_enable (seg_b),
        .o_display_enable (disp_b),
        .o_dot_enable     (dot_b),
        .o_frame_tick     (tick_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({disp_a, disp_b, seg_a, seg_b, dot_a, dot_b, tick_a, tick_b});
    endfunction

    // Must be called right after the negedge at which o_frame_tick is seen.
    // Sample k reflects slot k/8, count k%8; ldN_k < 0 disables that load.
    task automatic capture(input string name, input logic [0:3][0:6] ea,
                           input logic [0:3][0:6] eb, input logic [0:3] dot,
                           input int ld0_k, input logic [15:0] ld0_v,
                           input int ld1_k, input logic [15:0] ld1_v);
        logic [0:3] an;
        logic [0:6] sa, sb;
        logic       dt;
        int         s, c;
        i_dot = dot;
        for (int k = 0; k < 4 * RD; k++) begin
            @(negedge clk);
            s  = k / RD;
            c  = k % RD;
            an = 4'b1111;
            sa = SX;
            sb = SX;
            dt = 1'b1;
            if (c >= BC) begin
                an[s] = 1'b0;
                sa    = ea[s];
                sb    = eb[s];
                dt    = ~dot[s];
            end
            check($sformatf("%s_k%0d", name, k), outs(),
                  64'({an, an, sa, sb, dt, dt, (k == 4 * RD - 1), (k == 4 * RD - 1)}));
            i_load = 1'b0;
            if (k == ld0_k) begin
                i_load  = 1'b1;
                i_value = ld0_v;
            end
            if (k == ld1_k) begin
                i_load  = 1'b1;
                i_value = ld1_v;
            end
        end
        i_load = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        while (!tick_a && n < 80) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(tick_a), 64'(1'b1));
    endtask

    vec_t vecs[5];
    int   first_anode, first_tick;
    logic [0:3] first_anode_val;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        vecs[0] = '{value: 16'h0000, dot: 4'b0000, exp_a: {SX, SX, SX, S0}, exp_b: {S0, S0, S0, S0}};
        vecs[1] = '{value: 16'h1A3F, dot: 4'b0100, exp_a: {S1, SA, S3, SF}, exp_b: {S1, SA, S3, SF}};
        vecs[2] = '{value: 16'h0005, dot: 4'b0000, exp_a: {SX, SX, SX, S5}, exp_b: {S0, S0, S0, S5}};
        vecs[3] = '{value: 16'h8000, dot: 4'b1001, exp_a: {S8, S0, S0, S0}, exp_b: {S8, S0, S0, S0}};
        vecs[4] = '{value: 16'h00F0, dot: 4'b0010, exp_a: {SX, SX, SF, S0}, exp_b: {S0, S0, SF, S0}};

        rst     = 1'b1;
        i_value = '0;
        i_load  = 1'b0;
        i_dot   = '0;
        repeat (2) @(negedge clk);
        check("reset_state", outs(), 64'({4'hF, 4'hF, SX, SX, 4'b1100}));
        rst = 1'b0;

        // Run into digit 1, leave a pending load, then reset asynchronously.
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            i_load = 1'b0;
            if (n == 10) begin
                i_load  = 1'b1;
                i_value = 16'h1234;
            end
        end
        check("pre_reset_anode", 64'(disp_a), 64'(4'b1011));
        #2 rst = 1'b1;
        #1 check("reset_async", outs(), 64'({4'hF, 4'hF, SX, SX, 4'b1100}));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        first_anode     = -1;
        first_tick      = -1;
        first_anode_val = 4'b1111;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (first_anode < 0 && disp_a != 4'b1111) begin
                first_anode     = n;
                first_anode_val = disp_a;
            end
            if (first_tick < 0 && tick_a) first_tick = n;
        end
        check("first_anode_cycle", 64'(first_anode), 64'(3));
        check("first_anode_value", 64'(first_anode_val), 64'(4'b0111));
        check("first_tick_cycle", 64'(first_tick), 64'(32));

        wait_tick("sync_tick");

        // Each frame shows vecs[i] while loading vecs[i+1] early in the frame.
        for (int i = 0; i < 5; i++) begin
            capture($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b, vecs[i].dot,
                    (i < 4) ? 0 : -1, (i < 4) ? vecs[(i < 4) ? i + 1 : i].value : 16'h0,
                    -1, 16'h0);
        end

        // Two loads in one frame: the current frame is untouched, the last wins.
        capture("multi_cur", vecs[4].exp_a, vecs[4].exp_b, 4'b0000, 3, 16'h1111, 10, 16'h2222);
        // Load on the exact boundary cycle (sample 30 is the last slot-3 cycle).
        capture("multi_next", {S2, S2, S2, S2}, {S2, S2, S2, S2}, 4'b0000, 30, 16'hBEEF, -1, 16'h0);
        capture("boundary_load", {SLB, SE, SE, SF}, {SLB, SE, SE, SF}, 4'b0100, -1, 16'h0, -1, 16'h0);
        capture("boundary_hold", {SLB, SE, SE, SF}, {SLB, SE, SE, SF}, 4'b0000, -1, 16'h0, -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
